// File: rtl/rob_multi_wb.sv
// ============================================================================
//  Module   : rob_multi_wb
//  Brief    : In-order-retire reorder buffer with NUM_WB writeback channels,
//             branch/JALR resolution and flush at commit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rob_multi_wb #(
    parameter int DEPTH    = 16,
    parameter int IDX      = 4,
    parameter int NUM_WB   = 3,
    parameter int REG_BITS = 5
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  issue_valid,
    input  logic [2:0]            issue_kind,
    input  logic [REG_BITS-1:0]   issue_rd,
    input  logic [31:0]           issue_pc,
    input  logic [31:0]           issue_target,
    input  logic                  issue_pred,
    output logic                  issue_ready,
    output logic [IDX-1:0]        issue_id,
    input  logic [NUM_WB-1:0]     wb_valid,
    input  logic [NUM_WB*IDX-1:0] wb_id,
    input  logic [NUM_WB*32-1:0]  wb_value,
    input  logic [IDX-1:0]        q1_id,
    input  logic [IDX-1:0]        q2_id,
    output logic                  q1_ready,
    output logic                  q2_ready,
    output logic [31:0]           q1_value,
    output logic [31:0]           q2_value,
    output logic                  commit_valid,
    output logic [IDX-1:0]        commit_id,
    output logic [REG_BITS-1:0]   commit_rd,
    output logic [31:0]           commit_value,
    output logic                  commit_store,
    output logic                  br_valid,
    output logic [31:0]           br_pc,
    output logic                  br_taken,
    output logic                  br_pred,
    output logic                  flush,
    output logic [31:0]           flush_pc,
    output logic                  halted,
    output logic [IDX-1:0]        head_id,
    output logic [IDX:0]          count
);

    localparam logic [2:0] KIND_STORE  = 3'd2;
    localparam logic [2:0] KIND_BRANCH = 3'd3;
    localparam logic [2:0] KIND_JALR   = 3'd4;
    localparam logic [2:0] KIND_HALT   = 3'd5;

    logic                busy_q   [DEPTH];
    logic                busy_d   [DEPTH];
    logic                done_q   [DEPTH];
    logic                done_d   [DEPTH];
    logic [2:0]          kind_q   [DEPTH];
    logic [2:0]          kind_d   [DEPTH];
    logic [REG_BITS-1:0] rd_q     [DEPTH];
    logic [REG_BITS-1:0] rd_d     [DEPTH];
    logic [31:0]         pc_q     [DEPTH];
    logic [31:0]         pc_d     [DEPTH];
    logic [31:0]         target_q [DEPTH];
    logic [31:0]         target_d [DEPTH];
    logic                pred_q   [DEPTH];
    logic                pred_d   [DEPTH];
    logic [31:0]         value_q  [DEPTH];
    logic [31:0]         value_d  [DEPTH];

    logic [IDX-1:0]      head_q, head_d, tail_q, tail_d;
    logic [IDX:0]        count_q, count_d;
    logic                halted_q, halted_d;
    logic                commit_valid_q, commit_valid_d;
    logic [IDX-1:0]      commit_id_q, commit_id_d;
    logic [REG_BITS-1:0] commit_rd_q, commit_rd_d;
    logic [31:0]         commit_value_q, commit_value_d;
    logic                commit_store_q, commit_store_d;
    logic                br_valid_q, br_valid_d;
    logic [31:0]         br_pc_q, br_pc_d;
    logic                br_taken_q, br_taken_d;
    logic                br_pred_q, br_pred_d;
    logic                flush_q, flush_d;
    logic [31:0]         flush_pc_q, flush_pc_d;

    logic                w_issue_fire, w_commit_fire, w_flush_fire, w_mispredict;
    logic [2:0]          w_head_kind;
    logic [31:0]         w_head_value;

    assign issue_ready  = (count_q != (IDX+1)'(DEPTH)) && !halted_q;
    assign issue_id     = tail_q;
    assign head_id      = head_q;
    assign count        = count_q;
    assign halted       = halted_q;
    assign commit_valid = commit_valid_q;
    assign commit_id    = commit_id_q;
    assign commit_rd    = commit_rd_q;
    assign commit_value = commit_value_q;
    assign commit_store = commit_store_q;
    assign br_valid     = br_valid_q;
    assign br_pc        = br_pc_q;
    assign br_taken     = br_taken_q;
    assign br_pred      = br_pred_q;
    assign flush        = flush_q;
    assign flush_pc     = flush_pc_q;

    always_comb begin
        w_head_kind   = kind_q[head_q];
        w_head_value  = value_q[head_q];
        w_issue_fire  = rdy_in && issue_valid && issue_ready;
        w_commit_fire = rdy_in && busy_q[head_q] && done_q[head_q] && !halted_q;
        w_mispredict  = (w_head_kind == KIND_BRANCH) && (w_head_value[0] != pred_q[head_q]);
        w_flush_fire  = w_commit_fire && (w_mispredict || (w_head_kind == KIND_JALR));
    end

    // Operand lookup: an in-flight writeback to the same id bypasses the array.
    always_comb begin
        q1_ready = !busy_q[q1_id] || done_q[q1_id];
        q1_value = value_q[q1_id];
        q2_ready = !busy_q[q2_id] || done_q[q2_id];
        q2_value = value_q[q2_id];
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k] && (wb_id[k*IDX +: IDX] == q1_id)) begin
                q1_ready = 1'b1;
                q1_value = wb_value[k*32 +: 32];
            end
            if (wb_valid[k] && (wb_id[k*IDX +: IDX] == q2_id)) begin
                q2_ready = 1'b1;
                q2_value = wb_value[k*32 +: 32];
            end
        end
    end

    always_comb begin
        busy_d         = busy_q;
        done_d         = done_q;
        kind_d         = kind_q;
        rd_d           = rd_q;
        pc_d           = pc_q;
        target_d       = target_q;
        pred_d         = pred_q;
        value_d        = value_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        halted_d       = halted_q;
        commit_valid_d = 1'b0;
        commit_id_d    = commit_id_q;
        commit_rd_d    = commit_rd_q;
        commit_value_d = commit_value_q;
        commit_store_d = 1'b0;
        br_valid_d     = 1'b0;
        br_pc_d        = br_pc_q;
        br_taken_d     = br_taken_q;
        br_pred_d      = br_pred_q;
        flush_d        = 1'b0;
        flush_pc_d     = flush_pc_q;

        if (w_commit_fire) begin
            busy_d[head_q] = 1'b0;
            head_d         = head_q + IDX'(1);
            commit_valid_d = 1'b1;
            commit_id_d    = head_q;
            commit_rd_d    = rd_q[head_q];
            commit_value_d = w_head_value;
            case (w_head_kind)
                KIND_STORE: begin
                    commit_store_d = 1'b1;
                    commit_rd_d    = '0;
                end
                KIND_BRANCH: begin
                    br_valid_d  = 1'b1;
                    br_pc_d     = pc_q[head_q];
                    br_taken_d  = w_head_value[0];
                    br_pred_d   = pred_q[head_q];
                    commit_rd_d = '0;
                    if (w_mispredict) begin
                        flush_d    = 1'b1;
                        flush_pc_d = w_head_value[0] ? target_q[head_q] : pc_q[head_q] + 32'd4;
                    end
                end
                KIND_JALR: begin
                    commit_value_d = pc_q[head_q] + 32'd4;
                    flush_d        = 1'b1;
                    flush_pc_d     = w_head_value;
                end
                KIND_HALT: halted_d = 1'b1;
                default: ;
            endcase
        end

        // A redirect drops every in-flight entry, the concurrent issue and all writebacks.
        if (w_flush_fire) begin
            for (int i = 0; i < DEPTH; i++) busy_d[i] = 1'b0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (rdy_in) begin
            for (int k = 0; k < NUM_WB; k++) begin
                if (wb_valid[k] && busy_q[wb_id[k*IDX +: IDX]] && !done_q[wb_id[k*IDX +: IDX]]) begin
                    done_d[wb_id[k*IDX +: IDX]]  = 1'b1;
                    value_d[wb_id[k*IDX +: IDX]] = wb_value[k*32 +: 32];
                end
            end
            if (w_issue_fire) begin
                busy_d[tail_q]   = 1'b1;
                done_d[tail_q]   = 1'b0;
                kind_d[tail_q]   = issue_kind;
                rd_d[tail_q]     = issue_rd;
                pc_d[tail_q]     = issue_pc;
                target_d[tail_q] = issue_target;
                pred_d[tail_q]   = issue_pred;
                tail_d           = tail_q + IDX'(1);
            end
            count_d = count_q + (IDX+1)'(w_issue_fire) - (IDX+1)'(w_commit_fire);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_q[i]   <= 1'b0;
                done_q[i]   <= 1'b0;
                kind_q[i]   <= '0;
                rd_q[i]     <= '0;
                pc_q[i]     <= '0;
                target_q[i] <= '0;
                pred_q[i]   <= 1'b0;
                value_q[i]  <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            halted_q       <= 1'b0;
            commit_valid_q <= 1'b0;
            commit_id_q    <= '0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            commit_store_q <= 1'b0;
            br_valid_q     <= 1'b0;
            br_pc_q        <= '0;
            br_taken_q     <= 1'b0;
            br_pred_q      <= 1'b0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
        end else begin
            busy_q         <= busy_d;
            done_q         <= done_d;
            kind_q         <= kind_d;
            rd_q           <= rd_d;
            pc_q           <= pc_d;
            target_q       <= target_d;
            pred_q         <= pred_d;
            value_q        <= value_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            halted_q       <= halted_d;
            commit_valid_q <= commit_valid_d;
            commit_id_q    <= commit_id_d;
            commit_rd_q    <= commit_rd_d;
            commit_value_q <= commit_value_d;
            commit_store_q <= commit_store_d;
            br_valid_q     <= br_valid_d;
            br_pc_q        <= br_pc_d;
            br_taken_q     <= br_taken_d;
            br_pred_q      <= br_pred_d;
            flush_q        <= flush_d;
            flush_pc_q     <= flush_pc_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rob_multi_wb.sv
// ============================================================================
//  Module   : tb_rob_multi_wb
//  Brief    : Directed self-checking bench for rob_multi_wb.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rob_multi_wb;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        issue_valid;
    logic [2:0]  issue_kind;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pc;
    logic [31:0] issue_target;
    logic        issue_pred;
    logic        issue_ready;
    logic [3:0]  issue_id;
    logic [2:0]  wb_valid;
    logic [11:0] wb_id;
    logic [95:0] wb_value;
    logic [3:0]  q1_id, q2_id;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_value, q2_value;
    logic        commit_valid;
    logic [3:0]  commit_id;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic        commit_store;
    logic        br_valid;
    logic [31:0] br_pc;
    logic        br_taken;
    logic        br_pred;
    logic        flush;
    logic [31:0] flush_pc;
    logic        halted;
    logic [3:0]  head_id;
    logic [4:0]  count;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    rob_multi_wb #(.DEPTH(16), .IDX(4), .NUM_WB(3), .REG_BITS(5)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_kind(issue_kind), .issue_rd(issue_rd),
        .issue_pc(issue_pc), .issue_target(issue_target), .issue_pred(issue_pred),
        .issue_ready(issue_ready), .issue_id(issue_id),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
        .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_value(q1_value), .q2_value(q2_value),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_rd(commit_rd),
        .commit_value(commit_value), .commit_store(commit_store),
        .br_valid(br_valid), .br_pc(br_pc), .br_taken(br_taken), .br_pred(br_pred),
        .flush(flush), .flush_pc(flush_pc), .halted(halted),
        .head_id(head_id), .count(count)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_inputs();
        issue_valid = 0; issue_kind = 0; issue_rd = 0; issue_pc = 0;
        issue_target = 0; issue_pred = 0;
        wb_valid = 0; wb_id = 0; wb_value = 0; q1_id = 0; q2_id = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rdy_in = 1;
        rst_in = 0;
        tick();
        rst_in = 1;
        #1;
    endtask

    task automatic set_issue(input logic [2:0] k, input logic [4:0] rd,
                             input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
        issue_valid = 1; issue_kind = k; issue_rd = rd;
        issue_pc = pc; issue_target = tgt; issue_pred = pred;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", issue_ready); end
        total++; if (issue_id !== 4'd0) begin bad++; $display("FAIL reset_issue_id got=%0d exp=0", issue_id); end
        total++; if ({commit_valid, flush, halted, br_valid, commit_store} !== 5'b0) begin
            bad++; $display("FAIL reset_pulses got=%b exp=00000", {commit_valid, flush, halted, br_valid, commit_store}); end
        total++; if (flush_pc !== 32'd0) begin bad++; $display("FAIL reset_flush_pc got=%0h exp=0", flush_pc); end
    endtask

    task automatic test_rdy_hold();
        do_reset();
        rdy_in = 0;
        set_issue(3'd0, 5'd1, 32'h10, 32'h0, 1'b0);
        tick();
        total++; if (count !== 5'd0) begin bad++; $display("FAIL rdy_low_count got=%0d exp=0", count); end
        rdy_in = 1;
        tick();
        issue_valid = 0;
        total++; if (count !== 5'd1) begin bad++; $display("FAIL rdy_high_count got=%0d exp=1", count); end
    endtask

    task automatic test_alu_order();
        logic [4:0]  exp_rd  [3] = '{5'd1, 5'd2, 5'd3};
        logic [31:0] exp_val [3] = '{32'd10, 32'd20, 32'd30};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_issue(3'd0, 5'(i + 1), 32'(i * 4), 32'h0, 1'b0);
            tick();
        end
        issue_valid = 0;
        wb_valid = 3'b111;
        wb_id    = {4'd1, 4'd0, 4'd2};
        wb_value = {32'd20, 32'd10, 32'd30};
        tick();
        clear_inputs();
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL alu_early_commit got=%0b exp=0", commit_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (commit_valid !== 1'b1 || commit_id !== 4'(i) || commit_rd !== exp_rd[i] || commit_value !== exp_val[i]) begin
                bad++;
                $display("FAIL alu_commit%0d got=v%0b id%0d rd%0d val%0d exp=v1 id%0d rd%0d val%0d",
                         i, commit_valid, commit_id, commit_rd, commit_value, i, exp_rd[i], exp_val[i]);
            end
        end
        tick();
        total++; if (commit_valid !== 1'b0 || count !== 5'd0) begin
            bad++; $display("FAIL alu_drain got=v%0b cnt%0d exp=v0 cnt0", commit_valid, count); end
    endtask

    task automatic test_fill_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_issue(3'd0, 5'(i + 1), 32'(i * 4), 32'h0, 1'b0);
            tick();
        end
        total++; if (count !== 5'd16 || issue_ready !== 1'b0) begin
            bad++; $display("FAIL fill_full got=cnt%0d rdy%0b exp=cnt16 rdy0", count, issue_ready); end
        tick();
        total++; if (count !== 5'd16 || issue_id !== 4'd0) begin
            bad++; $display("FAIL fill_extra got=cnt%0d id%0d exp=cnt16 id0", count, issue_id); end
        clear_inputs();
        wb_valid = 3'b001; wb_id = 12'h000; wb_value = {64'h0, 32'h55};
        tick();
        clear_inputs();
        tick();
        total++; if (commit_valid !== 1'b1 || commit_id !== 4'd0 || commit_value !== 32'h55) begin
            bad++; $display("FAIL fill_commit got=v%0b id%0d val%0h exp=v1 id0 val55", commit_valid, commit_id, commit_value); end
        total++; if (count !== 5'd15 || issue_ready !== 1'b1 || issue_id !== 4'd0) begin
            bad++; $display("FAIL fill_room got=cnt%0d rdy%0b id%0d exp=cnt15 rdy1 id0", count, issue_ready, issue_id); end
        set_issue(3'd0, 5'd7, 32'h400, 32'h0, 1'b0);
        tick();
        clear_inputs();
        total++; if (count !== 5'd16 || issue_id !== 4'd1) begin
            bad++; $display("FAIL fill_wrap got=cnt%0d id%0d exp=cnt16 id1", count, issue_id); end
    endtask

    task automatic test_branch_flush();
        do_reset();
        set_issue(3'd3, 5'd0, 32'h100, 32'h140, 1'b0);
        tick();
        set_issue(3'd0, 5'd4, 32'h104, 32'h0, 1'b0);
        tick();
        clear_inputs();
        wb_valid = 3'b011; wb_id = {4'd0, 4'd1, 4'd0}; wb_value = {32'd0, 32'd7, 32'd1};
        tick();
        clear_inputs();
        tick();
        total++; if (br_valid !== 1'b1 || br_pc !== 32'h100 || br_taken !== 1'b1 || br_pred !== 1'b0) begin
            bad++; $display("FAIL br_update got=v%0b pc%0h t%0b p%0b exp=v1 pc100 t1 p0", br_valid, br_pc, br_taken, br_pred); end
        total++; if (flush !== 1'b1 || flush_pc !== 32'h140 || commit_rd !== 5'd0 || count !== 5'd0) begin
            bad++; $display("FAIL br_flush got=f%0b pc%0h rd%0d cnt%0d exp=f1 pc140 rd0 cnt0", flush, flush_pc, commit_rd, count); end
        tick();
        total++; if (flush !== 1'b0 || commit_valid !== 1'b0 || br_valid !== 1'b0 || issue_id !== 4'd0) begin
            bad++; $display("FAIL br_after got=f%0b c%0b b%0b id%0d exp=f0 c0 b0 id0", flush, commit_valid, br_valid, issue_id); end
    endtask

    task automatic test_jalr();
        do_reset();
        set_issue(3'd4, 5'd1, 32'h200, 32'h0, 1'b0);
        tick();
        clear_inputs();
        wb_valid = 3'b100; wb_id = {4'd0, 8'h00}; wb_value = {32'h3000, 64'h0};
        tick();
        clear_inputs();
        tick();
        total++; if (commit_valid !== 1'b1 || commit_rd !== 5'd1 || commit_value !== 32'h204) begin
            bad++; $display("FAIL jalr_commit got=v%0b rd%0d val%0h exp=v1 rd1 val204", commit_valid, commit_rd, commit_value); end
        total++; if (flush !== 1'b1 || flush_pc !== 32'h3000) begin
            bad++; $display("FAIL jalr_flush got=f%0b pc%0h exp=f1 pc3000", flush, flush_pc); end
    endtask

    task automatic test_same_id_wb();
        do_reset();
        set_issue(3'd0, 5'd2, 32'h300, 32'h0, 1'b0);
        tick();
        clear_inputs();
        q1_id = 4'd0;
        #1;
        total++; if (q1_ready !== 1'b0) begin bad++; $display("FAIL q1_pending got=%0b exp=0", q1_ready); end
        wb_valid = 3'b101; wb_id = {4'd0, 4'd0, 4'd0}; wb_value = {32'd9, 32'd0, 32'd5};
        #1;
        total++; if (q1_ready !== 1'b1 || q1_value !== 32'd9) begin
            bad++; $display("FAIL q1_bypass got=r%0b v%0d exp=r1 v9", q1_ready, q1_value); end
        tick();
        wb_valid = 0;
        #1;
        total++; if (q1_ready !== 1'b1 || q1_value !== 32'd9) begin
            bad++; $display("FAIL q1_stored got=r%0b v%0d exp=r1 v9", q1_ready, q1_value); end
        tick();
        total++; if (commit_valid !== 1'b1 || commit_value !== 32'd9) begin
            bad++; $display("FAIL same_id_commit got=v%0b val%0d exp=v1 val9", commit_valid, commit_value); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_issue(3'd0, 5'(i + 1), 32'(i * 4), 32'h0, 1'b0);
            tick();
        end
        clear_inputs();
        wb_valid = 3'b001; wb_id = 12'h000; wb_value = {64'h0, 32'h77};
        tick();
        clear_inputs();
        tick();
        total++; if (commit_valid !== 1'b1 || count !== 5'd5) begin
            bad++; $display("FAIL pre_reset got=v%0b cnt%0d exp=v1 cnt5", commit_valid, count); end
        #2;
        rst_in = 0;
        #1;
        total++; if (commit_valid !== 1'b0 || commit_value !== 32'd0 || commit_rd !== 5'd0 || count !== 5'd0 || issue_id !== 4'd0) begin
            bad++; $display("FAIL async_reset got=v%0b val%0h rd%0d cnt%0d id%0d exp=all0",
                            commit_valid, commit_value, commit_rd, count, issue_id); end
        rst_in = 1;
    endtask

    task automatic test_halt();
        do_reset();
        set_issue(3'd5, 5'd0, 32'h500, 32'h0, 1'b0);
        tick();
        clear_inputs();
        wb_valid = 3'b001; wb_id = 12'h000; wb_value = 96'h0;
        tick();
        clear_inputs();
        tick();
        total++; if (halted !== 1'b1 || issue_ready !== 1'b0) begin
            bad++; $display("FAIL halt got=h%0b rdy%0b exp=h1 rdy0", halted, issue_ready); end
        set_issue(3'd0, 5'd3, 32'h504, 32'h0, 1'b0);
        tick();
        clear_inputs();
        total++; if (count !== 5'd0 || halted !== 1'b1 || commit_valid !== 1'b0) begin
            bad++; $display("FAIL halt_sticky got=cnt%0d h%0b c%0b exp=cnt0 h1 c0", count, halted, commit_valid); end
    endtask

    initial begin
        clear_inputs();
        rdy_in = 1;
        rst_in = 0;
        #3;
        test_reset();
        test_rdy_hold();
        test_alu_order();
        test_fill_wrap();
        test_branch_flush();
        test_jalr();
        test_same_id_wb();
        test_async_reset();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
